pio_pin_controller: RTL and testbench

- Shares the 32 GPIO pads between NUM_SM PIO state machines.
- Each cycle it merges pin-value and pin-direction writes from all state machines, resolving overlaps by fixed priority, and holds the results in registers that drive the pads.
- Synchronises pad inputs and gives each state machine a rotated view of the pins, aligned to that state machine's IN base.
- Sits between the state-machine execute stages and the pad ring, in place of the per-machine pin glue.

---
 rtl/pio_pin_controller.sv | 130 +++++++++++++
 tb/tb_pio_pin_controller.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_pin_controller.sv
// pio_pin_controller: shares the 32 GPIO pads between NUM_SM PIO state
// machines. Merges per-SM pin value/direction writes (highest SM index
// wins), registers them onto the pads, flags same-kind overlaps, and
// returns a two-flop-synchronised, per-SM rotated view of the pad inputs.
// Ports: clock/reset (sync, active high); wr_valid/wr_kind/wr_data/
// wr_base/wr_count per-SM write requests; in_base/in_data per-SM input
// view; pad_in/pad_out/pad_oe pad ring; conflict, conflict_sticky and
// conflict_clear for overlap reporting.
module pio_pin_controller #(
  parameter int NUM_SM   = 4,
  parameter int NUM_PINS = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_SM-1:0]        wr_valid,
  input  logic [NUM_SM-1:0]        wr_kind,
  input  logic [NUM_SM*32-1:0]     wr_data,
  input  logic [NUM_SM*5-1:0]      wr_base,
  input  logic [NUM_SM*6-1:0]      wr_count,
  input  logic [NUM_SM*5-1:0]      in_base,
  output logic [NUM_SM*32-1:0]     in_data,
  input  logic [NUM_PINS-1:0]      pad_in,
  output logic [NUM_PINS-1:0]      pad_out,
  output logic [NUM_PINS-1:0]      pad_oe,
  output logic                     conflict,
  output logic                     conflict_sticky,
  input  logic                     conflict_clear
);

  // Shifts of 32 yield 0, so base 0 needs no special case.
  function automatic logic [31:0] rotl32(
    input logic [31:0] v,
    input logic [4:0]  b
  );
    logic [5:0] rb;
    rb = 6'd32 - {1'b0, b};
    return (v << b) | (v >> rb);
  endfunction

  function automatic logic [31:0] rotr32(
    input logic [31:0] v,
    input logic [4:0]  b
  );
    logic [5:0] rb;
    rb = 6'd32 - {1'b0, b};
    return (v >> b) | (v << rb);
  endfunction

  logic [31:0] mask [NUM_SM];
  logic [31:0] wdat [NUM_SM];

  logic [31:0] out_q, out_d;
  logic [31:0] oe_q, oe_d;
  logic [31:0] s1_q, s1_d;
  logic [31:0] s2_q, s2_d;
  logic        conflict_q, conflict_d;
  logic        sticky_q, sticky_d;

  for (genvar g = 0; g < NUM_SM; g++) begin : g_sm
    logic [5:0]  cnt_raw;
    logic [31:0] span;

    assign cnt_raw = wr_count[g*6 +: 6];

    // Counts of 32 and above select every pin.
    assign span = (cnt_raw >= 6'd32) ? '1
                : ((32'd1 << cnt_raw[4:0]) - 32'd1);

    assign mask[g] = rotl32(span, wr_base[g*5 +: 5]);
    assign wdat[g] = rotl32(wr_data[g*32 +: 32],
                            wr_base[g*5 +: 5]) & mask[g];

    assign in_data[g*32 +: 32] = rotr32(s2_q, in_base[g*5 +: 5]);
  end

  always_comb begin
    logic [31:0] seen0;
    logic [31:0] seen1;
    logic        hit;
    out_d = out_q;
    oe_d  = oe_q;
    seen0 = '0;
    seen1 = '0;
    hit   = 1'b0;
    // Ascending index: later (higher) SMs overwrite earlier ones.
    for (int i = 0; i < NUM_SM; i++) begin
      if (wr_valid[i]) begin
        if (wr_kind[i]) begin
          hit   = hit | (|(seen1 & mask[i]));
          seen1 = seen1 | mask[i];
          oe_d  = (oe_d & ~mask[i]) | wdat[i];
        end else begin
          hit   = hit | (|(seen0 & mask[i]));
          seen0 = seen0 | mask[i];
          out_d = (out_d & ~mask[i]) | wdat[i];
        end
      end
    end
    conflict_d = hit;
    // Sticky rises with the pulse, and a clear while the pulse is
    // still high loses.
    sticky_d = hit | conflict_q | (sticky_q & ~conflict_clear);
    s1_d = pad_in;
    s2_d = s1_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q      <= '0;
      oe_q       <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      conflict_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      out_q      <= out_d;
      oe_q       <= oe_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      conflict_q <= conflict_d;
      sticky_q   <= sticky_d;
    end
  end

  assign pad_out         = out_q;
  assign pad_oe          = oe_q;
  assign conflict        = conflict_q;
  assign conflict_sticky = sticky_q;

endmodule

// File: tb/tb_pio_pin_controller.sv
// tb_pio_pin_controller: directed scenarios plus randomized traffic
// checked against a per-pin behavioural model of the pin controller.
module tb_pio_pin_controller;

  localparam int N = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    wr_valid;
  logic [N-1:0]    wr_kind;
  logic [N*32-1:0] wr_data;
  logic [N*5-1:0]  wr_base;
  logic [N*6-1:0]  wr_count;
  logic [N*5-1:0]  in_base;
  logic [N*32-1:0] in_data;
  logic [31:0]     pad_in;
  logic [31:0]     pad_out;
  logic [31:0]     pad_oe;
  logic            conflict;
  logic            conflict_sticky;
  logic            conflict_clear;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_out, m_oe, m_s1, m_s2;
  logic        m_conf, m_sticky;

  always #5 clock = ~clock;

  pio_pin_controller #(.NUM_SM(N), .NUM_PINS(32)) dut (
    .clock(clock),
    .reset(reset),
    .wr_valid(wr_valid),
    .wr_kind(wr_kind),
    .wr_data(wr_data),
    .wr_base(wr_base),
    .wr_count(wr_count),
    .in_base(in_base),
    .in_data(in_data),
    .pad_in(pad_in),
    .pad_out(pad_out),
    .pad_oe(pad_oe),
    .conflict(conflict),
    .conflict_sticky(conflict_sticky),
    .conflict_clear(conflict_clear)
  );

  // Per pin: find which SMs cover it, take the highest one's bit.
  task automatic model_step();
    logic [31:0] no, noe;
    logic        c;
    if (reset) begin
      m_out = '0; m_oe = '0; m_s1 = '0; m_s2 = '0;
      m_conf = 1'b0; m_sticky = 1'b0;
      return;
    end
    no = m_out; noe = m_oe; c = 1'b0;
    for (int p = 0; p < 32; p++) begin
      int w0, w1;
      w0 = 0; w1 = 0;
      for (int i = 0; i < N; i++) begin
        int cnt, off;
        if (!wr_valid[i]) continue;
        cnt = int'(wr_count[i*6 +: 6]);
        if (cnt > 32) cnt = 32;
        off = (p - int'(wr_base[i*5 +: 5]) + 32) % 32;
        if (off < cnt) begin
          if (wr_kind[i]) begin
            w1++;
            noe[p] = wr_data[i*32 + off];
          end else begin
            w0++;
            no[p] = wr_data[i*32 + off];
          end
        end
      end
      if (w0 > 1 || w1 > 1) c = 1'b1;
    end
    m_sticky = c | m_conf | (m_sticky & ~conflict_clear);
    m_conf = c;
    m_s2 = m_s1;
    m_s1 = pad_in;
    m_out = no;
    m_oe = noe;
  endtask

  function automatic logic [31:0] m_view(input int i);
    logic [31:0] r;
    int b;
    b = int'(in_base[i*5 +: 5]);
    for (int k = 0; k < 32; k++) r[k] = m_s2[(k + b) % 32];
    return r;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_wr();
    wr_valid = '0; wr_kind = '0; wr_data = '0;
    wr_base = '0; wr_count = '0;
  endtask

  task automatic set_wr(input int i, input bit k, input int b,
                        input int c, input logic [31:0] d);
    wr_valid[i] = 1'b1;
    wr_kind[i] = k;
    wr_base[i*5 +: 5] = 5'(b);
    wr_count[i*6 +: 6] = 6'(c);
    wr_data[i*32 +: 32] = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; conflict_clear = 1'b0; pad_in = '0; in_base = '0;
    clr_wr();
    set_wr(0, 1'b1, 0, 32, 32'hFFFF_FFFF);
    tick();
    n_cmp++; if (pad_oe !== 32'h0) begin n_bad++;
      $display("FAIL rst_oe: got %h want %h", pad_oe, 32'h0); end
    n_cmp++; if (pad_out !== 32'h0) begin n_bad++;
      $display("FAIL rst_out: got %h want %h", pad_out, 32'h0); end
    n_cmp++; if ({conflict, conflict_sticky} !== 2'b00) begin n_bad++;
      $display("FAIL rst_conf: got %b%b want 00", conflict,
               conflict_sticky); end
    n_cmp++; if (in_data !== '0) begin n_bad++;
      $display("FAIL rst_in: got %h want 0", in_data); end
    reset = 1'b0;
    tick();
    n_cmp++; if (pad_oe !== 32'hFFFF_FFFF) begin n_bad++;
      $display("FAIL rst_release_oe: got %h want ffffffff", pad_oe); end
    n_cmp++; if (pad_out !== 32'h0) begin n_bad++;
      $display("FAIL rst_release_out: got %h want 0", pad_out); end
  endtask

  task automatic test_wrap();
    clr_wr();
    set_wr(1, 1'b0, 30, 4, 32'hF);
    tick();
    n_cmp++; if (pad_out !== 32'hC000_0003) begin n_bad++;
      $display("FAIL wrap_out: got %h want c0000003", pad_out); end
    n_cmp++; if (pad_oe !== 32'hFFFF_FFFF) begin n_bad++;
      $display("FAIL wrap_oe: got %h want ffffffff", pad_oe); end
    n_cmp++; if (conflict !== 1'b0) begin n_bad++;
      $display("FAIL wrap_conf: got %b want 0", conflict); end
  endtask

  task automatic test_priority();
    clr_wr();
    set_wr(0, 1'b0, 0, 8, 32'hFF);
    set_wr(3, 1'b0, 4, 8, 32'h00);
    tick();
    n_cmp++; if (pad_out !== 32'hC000_000F) begin n_bad++;
      $display("FAIL prio_out: got %h want c000000f", pad_out); end
    n_cmp++; if (conflict !== 1'b1) begin n_bad++;
      $display("FAIL prio_conf: got %b want 1", conflict); end
    n_cmp++; if (conflict_sticky !== 1'b1) begin n_bad++;
      $display("FAIL prio_sticky: got %b want 1", conflict_sticky); end
    clr_wr();
    conflict_clear = 1'b1;
    tick();
    n_cmp++; if (conflict !== 1'b0) begin n_bad++;
      $display("FAIL prio_pulse: got %b want 0", conflict); end
    n_cmp++; if (conflict_sticky !== 1'b1) begin n_bad++;
      $display("FAIL prio_setwins: got %b want 1", conflict_sticky); end
    tick();
    n_cmp++; if (conflict_sticky !== 1'b0) begin n_bad++;
      $display("FAIL prio_clear: got %b want 0", conflict_sticky); end
    conflict_clear = 1'b0;
    tick();
    n_cmp++; if (conflict_sticky !== 1'b0) begin n_bad++;
      $display("FAIL prio_hold0: got %b want 0", conflict_sticky); end
  endtask

  task automatic test_count();
    clr_wr();
    set_wr(2, 1'b0, 5, 0, 32'hFFFF_FFFF);
    set_wr(1, 1'b0, 5, 0, 32'hFFFF_FFFF);
    tick();
    n_cmp++; if (pad_out !== 32'hC000_000F) begin n_bad++;
      $display("FAIL cnt0_out: got %h want c000000f", pad_out); end
    n_cmp++; if (conflict !== 1'b0) begin n_bad++;
      $display("FAIL cnt0_conf: got %b want 0", conflict); end
    clr_wr();
    set_wr(2, 1'b0, 0, 40, 32'hA5A5_A5A5);
    tick();
    n_cmp++; if (pad_out !== 32'hA5A5_A5A5) begin n_bad++;
      $display("FAIL cnt40_out: got %h want a5a5a5a5", pad_out); end
  endtask

  task automatic test_input_sync();
    clr_wr();
    pad_in = '0;
    for (int i = 0; i < N; i++) in_base[i*5 +: 5] = 5'd8;
    tick();
    tick();
    pad_in = 32'h0000_0100;
    n_cmp++; if (in_data[31:0] !== 32'h0) begin n_bad++;
      $display("FAIL sync_e0: got %h want 0", in_data[31:0]); end
    tick();
    n_cmp++; if (in_data[31:0] !== 32'h0) begin n_bad++;
      $display("FAIL sync_e1: got %h want 0", in_data[31:0]); end
    tick();
    n_cmp++; if (in_data[31:0] !== 32'h1) begin n_bad++;
      $display("FAIL sync_e2: got %h want 1", in_data[31:0]); end
    in_base[5 +: 5] = 5'd0;
    #1;
    n_cmp++; if (in_data[63:32] !== 32'h100) begin n_bad++;
      $display("FAIL sync_base: got %h want 100", in_data[63:32]); end
  endtask

  task automatic test_mixed();
    clr_wr();
    set_wr(0, 1'b1, 0, 32, 32'h0);
    tick();
    clr_wr();
    set_wr(0, 1'b1, 0, 2, 32'h3);
    set_wr(1, 1'b0, 0, 2, 32'h2);
    tick();
    n_cmp++; if (pad_oe !== 32'h3) begin n_bad++;
      $display("FAIL mix_oe: got %h want 3", pad_oe); end
    n_cmp++; if (pad_out !== 32'hA5A5_A5A6) begin n_bad++;
      $display("FAIL mix_out: got %h want a5a5a5a6", pad_out); end
    n_cmp++; if (conflict !== 1'b0) begin n_bad++;
      $display("FAIL mix_conf: got %b want 0", conflict); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      reset = ($urandom_range(0, 63) == 0);
      conflict_clear = ($urandom_range(0, 7) == 0);
      pad_in = $urandom;
      in_base = N*5'($urandom);
      for (int i = 0; i < N; i++) begin
        wr_valid[i] = $urandom_range(0, 2) != 0;
        wr_kind[i] = $urandom_range(0, 1);
        wr_data[i*32 +: 32] = $urandom;
        wr_base[i*5 +: 5] = 5'($urandom);
        wr_count[i*6 +: 6] = $urandom_range(0, 1) ? 6'($urandom_range(0, 12))
                                                  : 6'($urandom);
      end
      tick();
      n_cmp++; if (pad_out !== m_out) begin n_bad++;
        $display("FAIL rnd_out it%0d: got %h want %h", it, pad_out, m_out); end
      n_cmp++; if (pad_oe !== m_oe) begin n_bad++;
        $display("FAIL rnd_oe it%0d: got %h want %h", it, pad_oe, m_oe); end
      n_cmp++; if (conflict !== m_conf) begin n_bad++;
        $display("FAIL rnd_conf it%0d: got %b want %b", it, conflict, m_conf); end
      n_cmp++; if (conflict_sticky !== m_sticky) begin n_bad++;
        $display("FAIL rnd_sticky it%0d: got %b want %b", it,
                 conflict_sticky, m_sticky); end
      for (int i = 0; i < N; i++) begin
        n_cmp++; if (in_data[i*32 +: 32] !== m_view(i)) begin n_bad++;
          $display("FAIL rnd_in%0d it%0d: got %h want %h", i, it,
                   in_data[i*32 +: 32], m_view(i)); end
      end
    end
    reset = 1'b0;
    conflict_clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_priority();
    test_count();
    test_input_sync();
    test_mixed();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
